// File: rtl/cache_pkg.sv
// Shared cache constants and the line-fill FSM state type.
package cache_pkg;

    localparam int unsigned LINE_WORDS  = 16;
    localparam int unsigned OFFSET_BITS = 4;
    localparam int unsigned ADDR_W      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } fill_state_e;

endpackage

// File: rtl/line_fill_responder.sv
// Line-fill responder: accepts a miss address, waits LATENCY cycles, then
// streams the 16 words of the line with valid/ready flow control.
// Optional macro FILL_CRITICAL_WORD_FIRST_EN starts the burst at the missing
// word and wraps modulo 16; otherwise every burst starts at word 0.
module line_fill_responder
    import cache_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_data,
    output logic [3:0]        rsp_word,
    output logic              rsp_last,
    output logic [31:0]       fill_count
);

    localparam int unsigned BASE_W = ADDR_W - OFFSET_BITS;
    localparam int unsigned WAIT_W = 8;
    localparam logic [WAIT_W-1:0]      WAIT_LAST = WAIT_W'(LATENCY - 1);
    localparam logic [OFFSET_BITS-1:0] LAST_BEAT = OFFSET_BITS'(LINE_WORDS - 1);
    localparam logic [OFFSET_BITS-1:0] PRE_LAST  = OFFSET_BITS'(LINE_WORDS - 2);

`ifdef FILL_CRITICAL_WORD_FIRST_EN
    localparam bit CWF_EN = 1'b1;
`else
    localparam bit CWF_EN = 1'b0;
`endif

    fill_state_e              state, state_n;
    logic [WAIT_W-1:0]        wait_cnt, wait_cnt_n;
    logic [OFFSET_BITS-1:0]   beat_cnt, beat_cnt_n;
    logic [BASE_W-1:0]        base, base_n;
    logic [OFFSET_BITS-1:0]   word_n;
    logic                     req_ready_n;
    logic                     rsp_valid_n;
    logic                     rsp_last_n;
    logic [ADDR_W-1:0]        rsp_data_n;
    logic [31:0]              fill_count_n;
    logic [OFFSET_BITS-1:0]   start_c;

    // Burst start offset: the requested word when critical-word-first is enabled.
    always_comb begin
        start_c = CWF_EN ? req_addr[OFFSET_BITS-1:0] : '0;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        wait_cnt_n   = wait_cnt;
        beat_cnt_n   = beat_cnt;
        base_n       = base;
        word_n       = rsp_word;
        req_ready_n  = req_ready;
        rsp_valid_n  = rsp_valid;
        rsp_last_n   = rsp_last;
        rsp_data_n   = rsp_data;
        fill_count_n = fill_count;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    fill_count_n = fill_count + 32'd1;
                    base_n       = req_addr[ADDR_W-1:OFFSET_BITS];
                    word_n       = start_c;
                    beat_cnt_n   = '0;
                    wait_cnt_n   = '0;
                    req_ready_n  = 1'b0;
                    if (LATENCY == 0) begin
                        state_n     = BURST;
                        rsp_valid_n = 1'b1;
                        rsp_last_n  = 1'b0;
                        rsp_data_n  = {req_addr[ADDR_W-1:OFFSET_BITS], start_c};
                    end else begin
                        state_n = WAIT;
                    end
                end
            end

            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_n     = BURST;
                    rsp_valid_n = 1'b1;
                    rsp_last_n  = 1'b0;
                    rsp_data_n  = {base, rsp_word};
                end else begin
                    wait_cnt_n = wait_cnt + WAIT_W'(1);
                end
            end

            BURST: begin
                if (rsp_ready) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_n     = IDLE;
                        rsp_valid_n = 1'b0;
                        rsp_last_n  = 1'b0;
                        req_ready_n = 1'b1;
                    end else begin
                        beat_cnt_n = beat_cnt + OFFSET_BITS'(1);
                        word_n     = rsp_word + OFFSET_BITS'(1);
                        rsp_data_n = {base, word_n};
                        rsp_last_n = (beat_cnt == PRE_LAST);
                    end
                end
            end

            default: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
                rsp_valid_n = 1'b0;
                rsp_last_n  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any fill in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            beat_cnt   <= '0;
            base       <= '0;
            rsp_word   <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_last   <= 1'b0;
            rsp_data   <= '0;
            fill_count <= '0;
        end else begin
            state      <= state_n;
            wait_cnt   <= wait_cnt_n;
            beat_cnt   <= beat_cnt_n;
            base       <= base_n;
            rsp_word   <= word_n;
            req_ready  <= req_ready_n;
            rsp_valid  <= rsp_valid_n;
            rsp_last   <= rsp_last_n;
            rsp_data   <= rsp_data_n;
            fill_count <= fill_count_n;
        end
    end

endmodule

// File: tb/tb_line_fill_responder.sv
// Self-checking bench for line_fill_responder: one instance with LATENCY=4,
// one with LATENCY=0, driven from a table of fill requests plus a reset
// mid-burst sequence. Honours FILL_CRITICAL_WORD_FIRST_EN for expectations.
module tb_line_fill_responder;

    typedef struct {
        logic        sel;         // 0: LATENCY=4 instance, 1: LATENCY=0 instance
        logic [31:0] addr;
        int          stall_at;    // beat index where rsp_ready drops, -1 none
        int          stall_len;
        logic        hold_valid;  // keep req_valid high through the burst
        logic [3:0]  first_word;
        logic [31:0] first_data;
        logic [31:0] stall_data;
        logic [3:0]  last_word;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        sel;
    logic [31:0] req_addr;
    logic        rsp_ready;

    logic        rv4, rv0;
    logic        req_ready4, rsp_valid4, rsp_last4;
    logic        req_ready0, rsp_valid0, rsp_last0;
    logic [31:0] rsp_data4, rsp_data0, fill_count4, fill_count0;
    logic [3:0]  rsp_word4, rsp_word0;

    logic        c_req_ready, c_rsp_valid, c_rsp_last;
    logic [31:0] c_rsp_data, c_fill_count;
    logic [3:0]  c_rsp_word;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] fc4 = 32'd0;
    logic [31:0] fc0 = 32'd0;
    vec_t        vecs [5];

    always #5 clk = ~clk;

    assign rv4 = req_valid & ~sel;
    assign rv0 = req_valid &  sel;

    assign c_req_ready  = sel ? req_ready0  : req_ready4;
    assign c_rsp_valid  = sel ? rsp_valid0  : rsp_valid4;
    assign c_rsp_last   = sel ? rsp_last0   : rsp_last4;
    assign c_rsp_data   = sel ? rsp_data0   : rsp_data4;
    assign c_rsp_word   = sel ? rsp_word0   : rsp_word4;
    assign c_fill_count = sel ? fill_count0 : fill_count4;

    line_fill_responder #(.LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(rv4), .req_addr(req_addr),
        .req_ready(req_ready4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data4), .rsp_word(rsp_word4), .rsp_last(rsp_last4),
        .fill_count(fill_count4)
    );

    line_fill_responder #(.LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_addr(req_addr),
        .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data0), .rsp_word(rsp_word0), .rsp_last(rsp_last0),
        .fill_count(fill_count0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Issue one fill from a negedge, follow it to the end, return at a negedge.
    task automatic run_fill(input vec_t v);
        int          cycles;
        int          beat;
        int          guard;
        int          lat;
        logic [3:0]  w;
        logic [31:0] exp_fc;

        sel = v.sel;
        lat = v.sel ? 0 : 4;
        #0;
        chk("req_ready_before", 32'(c_req_ready), 32'd1);
        req_addr  = v.addr;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (v.sel) begin fc0 = fc0 + 32'd1; exp_fc = fc0; end
        else       begin fc4 = fc4 + 32'd1; exp_fc = fc4; end
        if (!v.hold_valid) req_valid = 1'b0;
        chk("req_ready_busy", 32'(c_req_ready), 32'd0);
        chk("fill_count_accept", c_fill_count, exp_fc);

        cycles = 0;
        while (!c_rsp_valid && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
        chk("first_beat_latency", 32'(cycles), 32'(lat));

        beat  = 0;
        guard = 0;
        while (beat < 16 && guard < 200) begin
            guard++;
            chk("rsp_valid_in_burst", 32'(c_rsp_valid), 32'd1);
            if (c_rsp_valid) begin
                w = 4'(32'(v.first_word) + 32'(beat));
                chk("rsp_word", 32'(c_rsp_word), 32'(w));
                chk("rsp_data", c_rsp_data, {v.addr[31:4], w});
                chk("rsp_last", 32'(c_rsp_last), 32'(beat == 15));
                if (beat == 0) chk("first_data", c_rsp_data, v.first_data);
                if (beat == 15) chk("last_word", 32'(c_rsp_word), 32'(v.last_word));
                if (v.hold_valid) begin
                    chk("req_ready_ignored", 32'(c_req_ready), 32'd0);
                    chk("fill_count_ignored", c_fill_count, exp_fc);
                end
                if (beat == v.stall_at) begin
                    rsp_ready = 1'b0;
                    repeat (v.stall_len) begin
                        @(negedge clk);
                        chk("stall_valid", 32'(c_rsp_valid), 32'd1);
                        chk("stall_data", c_rsp_data, v.stall_data);
                        chk("stall_word", 32'(c_rsp_word), 32'(w));
                        chk("stall_last", 32'(c_rsp_last), 32'd0);
                    end
                    rsp_ready = 1'b1;
                end
                beat++;
            end
            @(negedge clk);
        end
        chk("beat_count", 32'(beat), 32'd16);
        req_valid = 1'b0;
        chk("rsp_valid_after", 32'(c_rsp_valid), 32'd0);
        chk("req_ready_after", 32'(c_req_ready), 32'd1);
        chk("fill_count_after", c_fill_count, exp_fc);
    endtask

    initial begin
        int cycles;

        //          sel   addr          stall len hold  fw     first         stall         lw
`ifdef FILL_CRITICAL_WORD_FIRST_EN
        vecs[0] = '{1'b0, 32'h0000_1234, -1, 0, 1'b0, 4'd4,  32'h0000_1234, 32'h0,        4'd3};
        vecs[1] = '{1'b0, 32'h0000_1234,  5, 3, 1'b0, 4'd4,  32'h0000_1234, 32'h0000_1239, 4'd3};
        vecs[2] = '{1'b1, 32'hFFFF_FFF8, -1, 0, 1'b1, 4'd8,  32'hFFFF_FFF8, 32'h0,        4'd7};
        vecs[3] = '{1'b0, 32'h0000_ABCD, -1, 0, 1'b0, 4'd13, 32'h0000_ABCD, 32'h0,        4'd12};
`else
        vecs[0] = '{1'b0, 32'h0000_1234, -1, 0, 1'b0, 4'd0,  32'h0000_1230, 32'h0,        4'd15};
        vecs[1] = '{1'b0, 32'h0000_1234,  5, 3, 1'b0, 4'd0,  32'h0000_1230, 32'h0000_1235, 4'd15};
        vecs[2] = '{1'b1, 32'hFFFF_FFF8, -1, 0, 1'b1, 4'd0,  32'hFFFF_FFF0, 32'h0,        4'd15};
        vecs[3] = '{1'b0, 32'h0000_ABCD, -1, 0, 1'b0, 4'd0,  32'h0000_ABC0, 32'h0,        4'd15};
`endif
        vecs[4] = '{1'b0, 32'h0000_0040, -1, 0, 1'b0, 4'd0,  32'h0000_0040, 32'h0,        4'd15};

        rst       = 1'b1;
        req_valid = 1'b0;
        sel       = 1'b0;
        req_addr  = 32'h0;
        rsp_ready = 1'b1;
        #12;
        chk("reset_req_ready4", 32'(req_ready4), 32'd1);
        chk("reset_rsp_valid4", 32'(rsp_valid4), 32'd0);
        chk("reset_rsp_last4", 32'(rsp_last4), 32'd0);
        chk("reset_rsp_data4", rsp_data4, 32'd0);
        chk("reset_rsp_word4", 32'(rsp_word4), 32'd0);
        chk("reset_fill_count4", fill_count4, 32'd0);
        chk("reset_req_ready0", 32'(req_ready0), 32'd1);
        chk("reset_fill_count0", fill_count0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_fill(vecs[i]);

        // Reset in the middle of a burst, between clock edges.
        sel       = 1'b0;
        req_addr  = 32'h0000_0100;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        fc4 = fc4 + 32'd1;
        cycles = 0;
        while (!rsp_valid4 && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
        chk("rst_seq_latency", 32'(cycles), 32'd4);
        repeat (7) @(negedge clk);
        chk("rst_seq_beat7_word", 32'(rsp_word4), 32'd7);
        chk("rst_seq_fill_count", fill_count4, fc4);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_rsp_valid", 32'(rsp_valid4), 32'd0);
        chk("rst_async_fill_count", fill_count4, 32'd0);
        chk("rst_async_req_ready", 32'(req_ready4), 32'd1);
        chk("rst_async_rsp_data", rsp_data4, 32'd0);
        chk("rst_async_rsp_last", 32'(rsp_last4), 32'd0);
        fc4 = 32'd0;
        fc0 = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // Request presented at deassertion: accepted on the very next edge.
        run_fill(vecs[4]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/line_fill_responder.md
LINE_FILL_RESPONDER -- requirements
Module: line_fill_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, giving the cycles between request acceptance and the first data beat (legal range 0..255).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset that is asynchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1 bit, line-fill request present.
REQ-005 SHALL have port req_addr, input, 32 bits, missing address.
REQ-006 SHALL have port req_ready, output, 1 bit, responder can accept a request.
REQ-007 SHALL have port rsp_valid, output, 1 bit, data beat present.
REQ-008 SHALL have port rsp_ready, input, 1 bit, requester accepts the beat.
REQ-009 SHALL have port rsp_data, output, 32 bits, fill word.
REQ-010 SHALL have port rsp_word, output, 4 bits, word offset of rsp_data within the line.
REQ-011 SHALL have port rsp_last, output, 1 bit, marks the final beat of the line.
REQ-012 SHALL have port fill_count, output, 32 bits, number of accepted fill requests.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and BURST; req_ready=1 only in IDLE.
REQ-014 SHALL accept a request on the edge E0 where req_valid and req_ready are both 1, latching line base {req_addr[31:4],4'b0} and start offset.
REQ-015 SHALL go IDLE->WAIT on acceptance when LATENCY>0, and IDLE->BURST when LATENCY=0.
REQ-016 SHALL count LATENCY edges in WAIT so that rsp_valid first rises at edge E0+LATENCY.
REQ-017 SHALL deliver exactly 16 beats per request, with rsp_data = line base + rsp_word (32-bit wrap).
REQ-018 SHALL deliver beats in offset order 0,1,...,15 by default (see REQ-026).
REQ-019 SHALL advance a beat only on an edge where rsp_valid and rsp_ready are both 1, and SHALL hold rsp_data, rsp_word and rsp_last stable while rsp_ready=0.
REQ-020 SHALL assert rsp_last only on the 16th beat; the handshake of that beat SHALL move the FSM to IDLE, with req_ready=1 in the following cycle (no acceptance during the last beat).
REQ-021 SHALL ignore req_valid outside IDLE, with no state or counter change.
REQ-022 SHALL increment fill_count by 1 on each acceptance, wrapping 0xFFFFFFFF->0.

Reset
REQ-023 SHALL, while rst=1 regardless of clk, force state IDLE, req_ready=1, rsp_valid=0, rsp_last=0, rsp_data=0, rsp_word=0, fill_count=0, and wait/beat counters=0.
REQ-024 SHALL abort any in-progress WAIT or BURST on rst; the aborted line is not resumed.
REQ-025 SHALL accept a request on the first rising edge after rst deasserts if req_valid=1.

Configuration
REQ-026 SHALL, when macro FILL_CRITICAL_WORD_FIRST_EN is defined, start the burst at offset req_addr[3:0] and increment modulo 16 (e.g. 13,14,15,0,...,12), with rsp_last on the 16th beat; without the macro, SHALL always start at offset 0.

Structure
REQ-027 SHALL take the constants LINE_WORDS=16, OFFSET_BITS=4, ADDR_W=32 and the FSM state typedef from shared package cache_pkg.
REQ-028 SHALL be a single module with no sub-module; the wait and beat counters are inline.

Verification
REQ-029 SHALL check the basic fill: LATENCY=4, rsp_ready=1, req_addr=0x00001234 at E0 -> rsp_valid rises at E0+4, data 0x00001230..0x0000123F with rsp_word 0..15, rsp_last on the 16th beat, and fill_count=1.
REQ-030 SHALL check backpressure: drop rsp_ready for 3 cycles at beat 5 -> rsp_data holds 0x00001235 and the beat count is still 16 with no duplicate or skipped beat.
REQ-031 SHALL check zero latency and ignored requests: LATENCY=0, req_addr=0xFFFFFFF8 -> first beat at E0 with data 0xFFFFFFF0..0xFFFFFFFF; req_valid held high during the burst -> req_ready=0 and fill_count unchanged until IDLE.
REQ-032 SHALL check critical word first: with FILL_CRITICAL_WORD_FIRST_EN defined, req_addr=0x0000ABCD -> rsp_word sequence 13,14,15,0..12, first data 0x0000ABCD, and rsp_last with rsp_word=12.
REQ-033 SHALL check reset mid-burst: assert rst at beat 7 between clock edges -> rsp_valid=0 and fill_count=0 immediately; after release, a new request at 0x00000040 produces a clean 16-beat fill.
